// File: rtl/rf_op_sequencer_if.sv
// rf_op_sequencer_if: command/response handshake plus register-file control bus
interface rf_op_sequencer_if #(parameter int W = 16);
  logic cmd_valid;
  logic cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_ra;
  logic [2:0] cmd_rb;
  logic [W-1:0] cmd_imm;
  logic done;
  logic err;
  logic [W-1:0] rsp_data;
  logic [2:0] rf_readnum;
  logic [2:0] rf_writenum;
  logic rf_write;
  logic [W-1:0] rf_data_in;
  logic [W-1:0] rf_data_out;
  modport slave (
    input cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_imm, rf_data_out,
    output cmd_ready, done, err, rsp_data, rf_readnum, rf_writenum, rf_write, rf_data_in
  );
  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_imm, rf_data_out,
    input cmd_ready, done, err, rsp_data, rf_readnum, rf_writenum, rf_write, rf_data_in
  );
endinterface

// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: sequences register-file read/write ports for LDI/COPY/SWAP/CLEAR/READ commands
module rf_op_sequencer #(
  parameter int W = 16,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input logic clk,
  input logic reset,
  rf_op_sequencer_if.slave bus
);
  localparam logic [2:0] LDI = 3'd0, COPY = 3'd1, SWAP = 3'd2, CLEAR = 3'd3, READ = 3'd4;
  typedef enum logic [2:0] {IDLE, RDA, RDB, WRA, WRB, CLR, DONE} state_t;
  state_t state;
  logic [2:0] op, ra, rb, cnt, rd_sel;
  logic [W-1:0] imm, tmp_a, tmp_b, rsp;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      op <= '0;
      ra <= '0;
      rb <= '0;
      imm <= '0;
      tmp_a <= '0;
      tmp_b <= '0;
      cnt <= '0;
      rd_sel <= '0;
      rsp <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          op <= bus.cmd_op;
          ra <= bus.cmd_ra;
          rb <= bus.cmd_rb;
          imm <= bus.cmd_imm;
          if (bus.cmd_op == COPY || bus.cmd_op == SWAP || bus.cmd_op == READ) rd_sel <= bus.cmd_ra;
          state <= bus.cmd_op == LDI ? WRB :
                   bus.cmd_op == CLEAR ? CLR :
                   (bus.cmd_op == COPY || bus.cmd_op == SWAP || bus.cmd_op == READ) ? RDA : DONE;
        end
        RDA: begin
          tmp_a <= bus.rf_data_out;
          if (op == READ) rsp <= bus.rf_data_out;
          if (op == SWAP) rd_sel <= rb;
          state <= op == SWAP ? RDB : op == COPY ? WRB : DONE;
        end
        RDB: begin
          tmp_b <= bus.rf_data_out;
          state <= WRA;
        end
        WRA: state <= WRB;
        WRB: state <= DONE;
        CLR: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  // LDI reuses the WRB slot but targets ra with the immediate
  always_comb begin
    bus.cmd_ready = state == IDLE;
    bus.done = state == DONE;
    bus.err = state == DONE && op > READ;
    bus.rsp_data = rsp;
    bus.rf_readnum = rd_sel;
    bus.rf_write = ~reset && (state == WRA || state == WRB || state == CLR);
    bus.rf_writenum = state == WRA ? ra : state == WRB ? (op == LDI ? ra : rb) : cnt;
    bus.rf_data_in = state == WRA ? tmp_b :
                     state == WRB ? (op == LDI ? imm : tmp_a) :
                     state == CLR ? CLR_VAL : '0;
  end
endmodule

// File: tb/tb_rf_op_sequencer.sv
// tb_rf_op_sequencer: table-driven, hand-written and random checks against an abstract register-file model
module tb_rf_op_sequencer;
  localparam logic [15:0] CLR = 16'h0000;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  logic [15:0] rf [8];
  logic [15:0] m [8];
  logic [15:0] last_rsp = '0;
  rf_op_sequencer_if #(.W(16)) bus ();
  rf_op_sequencer #(.W(16), .CLR_VAL(CLR)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always_ff @(posedge clk) if (bus.rf_write) rf[bus.rf_writenum] <= bus.rf_data_in;
  assign bus.rf_data_out = rf[bus.rf_readnum];
  typedef struct {
    logic [2:0] op, ra, rb;
    logic [15:0] imm;
    int lat, nwr;
    logic err;
  } vec_t;
  vec_t tbl[$];
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction
  function automatic vec_t mk(logic [2:0] op, ra, rb, logic [15:0] imm, int lat, nwr, logic err);
    vec_t v;
    v.op = op; v.ra = ra; v.rb = rb; v.imm = imm; v.lat = lat; v.nwr = nwr; v.err = err;
    return v;
  endfunction
  function automatic int lat_of(logic [2:0] op);
    return op == 3'd0 ? 2 : op == 3'd1 ? 3 : op == 3'd2 ? 5 : op == 3'd3 ? 9 : op == 3'd4 ? 2 : 1;
  endfunction
  // Entered and left at a negedge with cmd_ready high; nwr < 0 means "as many as the model predicts"
  task automatic run_cmd(input logic [2:0] op, ra, rb, input logic [15:0] imm,
                         input int exp_lat, exp_nwr, input logic exp_err);
    logic [18:0] exp_w[$];
    logic [15:0] exp_rsp, t;
    int n, lat, nwr, busy;
    exp_rsp = op == 3'd4 ? m[ra] : last_rsp;
    case (op)
      3'd0: exp_w.push_back({ra, imm});
      3'd1: exp_w.push_back({rb, m[ra]});
      3'd2: begin exp_w.push_back({ra, m[rb]}); exp_w.push_back({rb, m[ra]}); end
      3'd3: for (int i = 0; i < 8; i++) exp_w.push_back({3'(i), CLR});
      default: ;
    endcase
    if (exp_nwr < 0) exp_nwr = exp_w.size();
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_ra = ra; bus.cmd_rb = rb; bus.cmd_imm = imm;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", n < 50, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'($urandom); bus.cmd_ra = 3'($urandom); bus.cmd_rb = 3'($urandom);
    bus.cmd_imm = 16'($urandom);
    lat = 1; nwr = 0; busy = 0;
    while (1) begin
      busy += int'(bus.cmd_ready);
      if (bus.rf_write) begin
        nwr++;
        if (exp_w.size() == 0) chk("extra_write", {bus.rf_writenum, bus.rf_data_in}, 0);
        else chk("write_addr_data", {bus.rf_writenum, bus.rf_data_in}, exp_w.pop_front());
      end
      if (bus.done || lat >= 20) break;
      @(negedge clk);
      lat++;
    end
    chk("done_seen", bus.done, 1);
    chk("latency", lat, exp_lat);
    chk("write_count", nwr, exp_nwr);
    chk("ready_low_busy", busy, 0);
    chk("err", bus.err, exp_err);
    chk("rsp_data", bus.rsp_data, exp_rsp);
    case (op)
      3'd0: m[ra] = imm;
      3'd1: m[rb] = m[ra];
      3'd2: begin t = m[ra]; m[ra] = m[rb]; m[rb] = t; end
      3'd3: for (int i = 0; i < 8; i++) m[i] = CLR;
      3'd4: last_rsp = m[ra];
      default: ;
    endcase
    @(negedge clk);
    chk("ready_after_done", bus.cmd_ready, 1);
  endtask
  initial begin
    logic [18:0] wq[$];
    int d1, d2, busy, nw, seen_done;
    logic rdy4;
    logic [2:0] op;
    for (int i = 0; i < 8; i++) m[i] = '0;
    tbl.push_back(mk(3'd3, 0, 0, 0, 9, 8, 0));
    tbl.push_back(mk(3'd0, 3, 0, 16'hBEEF, 2, 1, 0));
    tbl.push_back(mk(3'd4, 3, 0, 0, 2, 0, 0));
    tbl.push_back(mk(3'd0, 1, 0, 16'h1234, 2, 1, 0));
    tbl.push_back(mk(3'd0, 6, 0, 16'hABCD, 2, 1, 0));
    tbl.push_back(mk(3'd2, 1, 6, 0, 5, 2, 0));
    tbl.push_back(mk(3'd4, 1, 0, 0, 2, 0, 0));
    tbl.push_back(mk(3'd4, 6, 0, 0, 2, 0, 0));
    for (int r = 0; r < 8; r++) tbl.push_back(mk(3'd0, 3'(r), 0, 16'h00FF, 2, 1, 0));
    tbl.push_back(mk(3'd3, 0, 0, 0, 9, 8, 0));
    for (int r = 0; r < 8; r++) tbl.push_back(mk(3'd4, 3'(r), 0, 0, 2, 0, 0));
    tbl.push_back(mk(3'd0, 2, 0, 16'h5A5A, 2, 1, 0));
    tbl.push_back(mk(3'd0, 4, 0, 16'h4444, 2, 1, 0));
    tbl.push_back(mk(3'd6, 2, 4, 16'hFFFF, 1, 0, 1));
    tbl.push_back(mk(3'd5, 1, 1, 16'h1111, 1, 0, 1));
    tbl.push_back(mk(3'd2, 3, 3, 0, 5, 2, 0));
    reset = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_ra = 3'd3; bus.cmd_rb = 3'd0; bus.cmd_imm = 16'hFFFF;
    repeat (2) @(negedge clk);
    chk("rst_write_gate", bus.rf_write, 0);
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rsp", bus.rsp_data, 0);
    chk("rst_readnum", bus.rf_readnum, 0);
    chk("rst_writenum", bus.rf_writenum, 0);
    chk("rst_data_in", bus.rf_data_in, 0);
    @(negedge clk);
    chk("no_accept_in_reset", {bus.cmd_ready, bus.rf_write}, 2'b10);
    foreach (tbl[i]) run_cmd(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].imm, tbl[i].lat, tbl[i].nwr, tbl[i].err);
    // COPY 2->7 with cmd_valid held so COPY 4->4 waits for cmd_ready
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd1; bus.cmd_ra = 3'd2; bus.cmd_rb = 3'd7;
    d1 = 0; d2 = 0; busy = 0; rdy4 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) begin bus.cmd_ra = 3'd4; bus.cmd_rb = 3'd4; end
      if (c == 5) bus.cmd_valid = 1'b0;
      if (bus.done) begin if (d1 == 0) d1 = c; else d2 = c; end
      if (bus.rf_write) wq.push_back({bus.rf_writenum, bus.rf_data_in});
      if (c <= 3) busy += int'(bus.cmd_ready);
      if (c == 4) rdy4 = bus.cmd_ready;
    end
    chk("hold_first_done", d1, 3);
    chk("hold_second_done", d2, 7);
    chk("hold_busy_ready", busy, 0);
    chk("hold_ready_c4", rdy4, 1);
    chk("hold_nwrites", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("hold_write0", wq[0], {3'd7, m[2]});
      chk("hold_write1", wq[1], {3'd4, m[4]});
    end
    m[7] = m[2];
    run_cmd(3'd4, 7, 0, 0, 2, 0, 0);
    run_cmd(3'd4, 4, 0, 0, 2, 0, 0);
    // SWAP aborted by reset in its second write cycle
    run_cmd(3'd0, 0, 0, 16'h0001, 2, 1, 0);
    run_cmd(3'd0, 5, 0, 16'h0005, 2, 1, 0);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd2; bus.cmd_ra = 3'd0; bus.cmd_rb = 3'd5;
    seen_done = 0; nw = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) bus.cmd_valid = 1'b0;
      seen_done += int'(bus.done);
      if (c <= 3) nw += int'(bus.rf_write);
    end
    reset = 1'b1;
    #1 chk("abort_write_gate", bus.rf_write, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_no_done", seen_done + int'(bus.done), 0);
    chk("abort_writes", nw, 1);
    chk("abort_ready", bus.cmd_ready, 1);
    chk("abort_rsp", bus.rsp_data, 0);
    m[0] = m[5];
    last_rsp = '0;
    run_cmd(3'd4, 0, 0, 0, 2, 0, 0);
    run_cmd(3'd4, 5, 0, 0, 2, 0, 0);
    for (int k = 0; k < 80; k++) begin
      op = 3'($urandom_range(0, 9) > 7 ? 4 : $urandom_range(0, 7));
      run_cmd(op, 3'($urandom), 3'($urandom), 16'($urandom), lat_of(op), -1, op > 3'd4);
    end
    for (int r = 0; r < 8; r++) run_cmd(3'd4, 3'(r), 0, 0, 2, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
